// File: rtl/periodic_framer_sched_pkg.sv
// Shared definitions for the periodic framer burst scheduler: state
// encoding, command field layout and the short-burst write decision.
package periodic_framer_sched_pkg;

   // Two-bit scheduler state encoding
   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_DELAY_ENC  = 2'd1;
   localparam logic [1:0] ST_CONFIG_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_DELAY  = ST_DELAY_ENC,
      ST_CONFIG = ST_CONFIG_ENC
   } state_t;

   // Command word layout: {num_symbols[15:0], delay[31:0]}
   localparam int CMD_W     = 48;
   localparam int NSYM_LSB  = 32;
   localparam int NSYM_W    = 16;
   localparam int DELAY_LSB = 0;

   // A shortened burst is programmed only when the requested count is
   // non-zero and strictly below the framer's configured maximum;
   // otherwise the framer runs its full-length burst.
   function automatic logic short_write(input logic [NSYM_W-1:0] nsym,
                                        input logic [NSYM_W-1:0] nsym_max);
      return (nsym != '0) && (nsym < nsym_max);
   endfunction

endpackage

// File: rtl/periodic_framer_sched.sv
// Burst scheduler: turns queued {num_symbols, delay} commands into a
// per-sample trigger stream for the periodic framer, marks the burst-start
// sample with tlast, and programs the framer's short symbol count in the
// cycle right after the trigger beat is accepted (framer in offset phase).
module periodic_framer_sched
   import periodic_framer_sched_pkg::*;
#(
   parameter int SR_NUMBER_SYMBOLS_SHORT = 4,
   parameter int DELAY_W                 = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [CMD_W-1:0]  cmd_tdata,
   input  logic              cmd_tvalid,
   output logic              cmd_tready,
   input  logic [15:0]       numsymbols_max,
   input  logic              free_run,
   output logic [31:0]       trig_tdata,
   output logic              trig_tlast,
   output logic              trig_tvalid,
   input  logic              trig_tready,
   output logic              fr_set_stb,
   output logic [7:0]        fr_set_addr,
   output logic [31:0]       fr_set_data,
   input  logic              fr_eof,
   output logic              busy,
   output logic [15:0]       bursts_done
);

   state_t              state_reg, state_next;
   logic [DELAY_W-1:0]  cnt_reg, cnt_next;
   logic [NSYM_W-1:0]   nsym_reg, nsym_next;
   logic [31:0]         seq_reg, seq_next;
   logic                cmd_ready_reg;
   logic                eof_d_reg;
   logic [15:0]         done_reg;
   logic                srst;

   // clear behaves exactly like reset
   assign srst = reset | clear;

   assign cmd_tready  = cmd_ready_reg;
   assign trig_tdata  = seq_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign bursts_done = done_reg;

   // Next-state, counter updates and combinational stream/settings outputs
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      nsym_next   = nsym_reg;
      seq_next    = seq_reg;
      trig_tvalid = 1'b0;
      trig_tlast  = 1'b0;
      fr_set_stb  = 1'b0;
      fr_set_addr = 8'd0;
      fr_set_data = 32'd0;
      case (state_reg)
         ST_IDLE: begin
            // cmd_ready_reg is low only in the cycle(s) of reset, which keeps
            // free-run beats quiet while the block is held in reset.
            trig_tvalid = free_run & cmd_ready_reg;
            if (cmd_tvalid && cmd_ready_reg) begin
               nsym_next  = cmd_tdata[NSYM_LSB +: NSYM_W];
               cnt_next   = cmd_tdata[DELAY_LSB +: DELAY_W];
               state_next = ST_DELAY;
            end
         end
         ST_DELAY: begin
            trig_tvalid = 1'b1;
            trig_tlast  = (cnt_reg == '0);
            if (trig_tready) begin
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - DELAY_W'(1);
               end else begin
                  seq_next   = seq_reg + 32'd1;
                  state_next = ST_CONFIG;
               end
            end
         end
         ST_CONFIG: begin
            if (short_write(nsym_reg, numsymbols_max)) begin
               fr_set_stb  = 1'b1;
               fr_set_addr = 8'(SR_NUMBER_SYMBOLS_SHORT);
               fr_set_data = {16'd0, nsym_reg};
            end
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, counters and the registered command-ready flag
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         nsym_reg      <= '0;
         seq_reg       <= '0;
         cmd_ready_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         nsym_reg      <= nsym_next;
         seq_reg       <= seq_next;
         cmd_ready_reg <= (state_next == ST_IDLE);
      end
   end

   // Count framer end-of-burst rising edges, independent of scheduler state
   always_ff @(posedge clk) begin
      if (srst) begin
         eof_d_reg <= 1'b0;
         done_reg  <= '0;
      end else begin
         eof_d_reg <= fr_eof;
         if (fr_eof && !eof_d_reg) begin
            done_reg <= done_reg + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_periodic_framer_sched.sv
// Self-checking bench for periodic_framer_sched: table-driven command
// vectors, hand-written corner sequences and a randomized run, all checked
// every cycle against a burst-level reference model.
module tb_periodic_framer_sched;

   logic        clk = 1'b0;
   logic        reset, clear;
   logic [47:0] cmd_tdata;
   logic        cmd_tvalid, cmd_tready;
   logic [15:0] numsymbols_max;
   logic        free_run;
   logic [31:0] trig_tdata;
   logic        trig_tlast, trig_tvalid, trig_tready;
   logic        fr_set_stb;
   logic [7:0]  fr_set_addr;
   logic [31:0] fr_set_data;
   logic        fr_eof;
   logic        busy;
   logic [15:0] bursts_done;

   always #5 clk = ~clk;

   periodic_framer_sched dut (
      .clk(clk), .reset(reset), .clear(clear),
      .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
      .numsymbols_max(numsymbols_max), .free_run(free_run),
      .trig_tdata(trig_tdata), .trig_tlast(trig_tlast),
      .trig_tvalid(trig_tvalid), .trig_tready(trig_tready),
      .fr_set_stb(fr_set_stb), .fr_set_addr(fr_set_addr),
      .fr_set_data(fr_set_data), .fr_eof(fr_eof),
      .busy(busy), .bursts_done(bursts_done)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model (burst-level view) ----------------
   // m_left: samples still to emit before the trigger beat (-1 = no burst)
   longint m_left = -1;
   bit     m_cfg = 0;        // settings-write slot pending this cycle
   bit     m_ready = 0;      // command port open
   int     m_nsym = 0;
   int     m_seq = 0;
   int     m_done = 0;
   bit     m_eof_prev = 0;
   bit     acc_pulse = 0;
   int     cyc = 0;

   // observation counters
   int     obs_nonlast, obs_trig, obs_stb, first_trig_cyc, rise_cyc;
   logic [31:0] obs_data, last_tdata;
   bit     prev_rdy = 0;

   task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clr_obs();
      obs_nonlast = 0; obs_trig = 0; obs_stb = 0; obs_data = 0;
      last_tdata = 0; first_trig_cyc = -1; rise_cyc = -1;
   endtask

   // One clock: observe + compare at negedge, advance model at posedge.
   task automatic step();
      bit exp_valid, exp_last, exp_stb, exp_busy;
      @(negedge clk);
      if (trig_tvalid === 1'b1 && trig_tready) begin
         if (trig_tlast === 1'b1) begin
            obs_trig++;
            last_tdata = trig_tdata;
            if (first_trig_cyc < 0) first_trig_cyc = cyc;
         end else begin
            obs_nonlast++;
         end
      end
      if (fr_set_stb === 1'b1) begin
         obs_stb++;
         obs_data = fr_set_data;
      end
      if (cmd_tready === 1'b1 && !prev_rdy && obs_trig > 0 && rise_cyc < 0) rise_cyc = cyc;
      prev_rdy = (cmd_tready === 1'b1);

      exp_busy  = (m_left >= 0) || m_cfg;
      exp_valid = (m_left >= 0) ? 1'b1 : (!m_cfg && free_run && m_ready);
      exp_last  = (m_left == 0);
      exp_stb   = m_cfg && (m_nsym != 0) && (m_nsym < int'(numsymbols_max));
      chk("cmd_tready", cmd_tready, m_ready);
      chk("trig_tvalid", trig_tvalid, exp_valid);
      chk("trig_tlast", trig_tlast, exp_last);
      chk("busy", busy, exp_busy);
      chk("fr_set_stb", fr_set_stb, exp_stb);
      chk("bursts_done", bursts_done, m_done & 16'hFFFF);
      if (exp_last) chk("trig_tdata", trig_tdata, m_seq);
      if (exp_stb) begin
         chk("fr_set_addr", fr_set_addr, 8'd4);
         chk("fr_set_data", fr_set_data, m_nsym);
      end

      @(posedge clk);
      acc_pulse = 0;
      if (reset || clear) begin
         m_left = -1; m_cfg = 0; m_ready = 0; m_seq = 0;
         m_done = 0; m_eof_prev = 0;
      end else begin
         if (fr_eof && !m_eof_prev) m_done++;
         m_eof_prev = fr_eof;
         if (m_cfg) begin
            m_cfg = 0;
            m_ready = 1;
         end else if (m_left >= 0) begin
            if (trig_tready) begin
               if (m_left == 0) begin
                  $display("trigger seq=%0d nsym=%0d max=%0d cycle=%0d", m_seq, m_nsym, numsymbols_max, cyc);
                  m_seq++;
                  m_cfg = 1;
                  m_left = -1;
               end else begin
                  m_left--;
               end
            end
         end else if (m_ready && cmd_tvalid) begin
            m_left = longint'(cmd_tdata[31:0]);
            m_nsym = int'(cmd_tdata[47:32]);
            m_ready = 0;
            acc_pulse = 1;
            $display("command accepted delay=%0d nsym=%0d cycle=%0d", m_left, m_nsym, cyc);
         end else begin
            m_ready = 1;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (!(m_left < 0 && !m_cfg && m_ready) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk({name, "_idle_timeout"}, 1, 0);
   endtask

   task automatic send_cmd(string name, int d, int n);
      int k = 0;
      cmd_tdata  = {n[15:0], d[31:0]};
      cmd_tvalid = 1'b1;
      do begin
         step();
         k++;
      end while (!acc_pulse && k < 50);
      if (!acc_pulse) chk({name, "_accept_timeout"}, 1, 0);
      cmd_tvalid = 1'b0;
   endtask

   typedef struct {
      int delay;
      int nsym;
      int nmax;
      int exp_stb;
      int exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{3, 2, 8, 1, 2};
      vecs[1] = '{0, 8, 8, 0, 0};
      vecs[2] = '{0, 0, 8, 0, 0};
      vecs[3] = '{1, 7, 8, 1, 7};
      vecs[4] = '{2, 9, 8, 0, 0};
      vecs[5] = '{4, 1, 16, 1, 1};

      reset = 1; clear = 0; cmd_tdata = 0; cmd_tvalid = 0;
      numsymbols_max = 16'd8; free_run = 1; trig_tready = 1; fr_eof = 0;
      clr_obs();
      repeat (3) step();
      chk("reset_tdata", trig_tdata, 0);
      chk("reset_addr", fr_set_addr, 0);
      chk("reset_data", fr_set_data, 0);
      reset = 0; free_run = 0;
      step();

      // table-driven commands
      for (int i = 0; i < 6; i++) begin
         numsymbols_max = vecs[i].nmax[15:0];
         clr_obs();
         send_cmd("vec", vecs[i].delay, vecs[i].nsym);
         wait_idle("vec");
         chk("vec_nonlast", obs_nonlast, vecs[i].delay);
         chk("vec_trig", obs_trig, 1);
         chk("vec_tdata", last_tdata, i);
         chk("vec_stb", obs_stb, vecs[i].exp_stb);
         if (vecs[i].exp_stb != 0) chk("vec_data", obs_data, vecs[i].exp_data);
      end

      // stalls during delay=5
      clr_obs();
      send_cmd("stall", 5, 3);
      for (int k = 0; k < 200 && (m_left >= 0 || m_cfg); k++) begin
         trig_tready = ($urandom_range(0, 2) != 0);
         step();
      end
      trig_tready = 1;
      wait_idle("stall");
      chk("stall_nonlast", obs_nonlast, 5);
      chk("stall_trig", obs_trig, 1);

      // two queued commands after reset
      reset = 1; step(); reset = 0; step();
      clr_obs();
      numsymbols_max = 16'd8;
      send_cmd("q1", 1, 2);
      send_cmd("q2", 0, 3);
      wait_idle("q2");
      chk("queue_trig", obs_trig, 2);
      chk("queue_tdata2", last_tdata, 1);
      chk("queue_ready_gap", rise_cyc - first_trig_cyc, 2);

      // free-run idle behaviour
      clr_obs(); free_run = 1;
      repeat (5) step();
      chk("freerun_beats", obs_nonlast, 5);
      clr_obs(); free_run = 0;
      repeat (5) step();
      chk("norun_beats", obs_nonlast, 0);

      // clear mid-delay
      clr_obs();
      send_cmd("clr", 5, 2);
      for (int k = 0; k < 20 && m_left != 2; k++) step();
      clear = 1; step(); clear = 0;
      repeat (3) step();
      chk("clear_trig", obs_trig, 0);
      chk("clear_stb", obs_stb, 0);
      chk("clear_busy", busy, 0);

      // eof edge counting
      for (int p = 0; p < 3; p++) begin
         fr_eof = 1; step(); fr_eof = 0; step();
      end
      chk("eof_three", bursts_done, 3);
      fr_eof = 1; repeat (4) step(); fr_eof = 0; step();
      chk("eof_held", bursts_done, 4);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         if (acc_pulse) cmd_tvalid = 0;
         if (!cmd_tvalid && $urandom_range(0, 3) == 0) begin
            cmd_tdata = {16'($urandom_range(0, 10)), 32'($urandom_range(0, 6))};
            cmd_tvalid = 1;
         end
         trig_tready    = ($urandom_range(0, 3) != 0);
         numsymbols_max = 16'($urandom_range(4, 12));
         if ($urandom_range(0, 15) == 0) free_run = ~free_run;
         fr_eof = ($urandom_range(0, 2) == 0);
         clear  = ($urandom_range(0, 59) == 0);
         step();
      end
      clear = 0; cmd_tvalid = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/periodic_framer_sched.md
# periodic_framer_sched

Burst scheduler that drives the periodic framer's trigger input and its short-burst symbol-count register. It accepts queued burst commands (sample delay and symbol count) and emits a per-sample trigger stream in lockstep with the framer's sample input. It asserts `tlast` on the burst-start sample and writes the framer's short-count setting immediately after the trigger is accepted. It sits between the host command path (fed from an external `axi_fifo`) and the framer.

## Interface
- `SR_NUMBER_SYMBOLS_SHORT`, 4: settings address written to the framer for shortened bursts.
- `DELAY_W`, 32: width of the delay field and the delay counter.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: synchronous, active-high soft reset; same effect as `reset`.
- `cmd_tdata` in 48: `[47:32]` num_symbols, `[31:0]` delay in samples.
- `cmd_tvalid` in 1 / `cmd_tready` out 1: command handshake.
- `numsymbols_max` in 16: framer's configured maximum symbols per burst.
- `free_run` in 1: 1 means emit non-last trigger beats while idle, so samples flow and the framer discards them. 0 means hold `trig_tvalid` low while idle, which back-pressures samples.
- `trig_tdata` out 32: burst sequence number (first burst = 0). Don't-care on non-last beats.
- `trig_tlast` out 1: burst-start marker.
- `trig_tvalid` out 1 / `trig_tready` in 1: trigger stream to the framer.
- `fr_set_stb` out 1, `fr_set_addr` out 8, `fr_set_data` out 32: settings write to the framer.
- `fr_eof` in 1: framer `eof` output.
- `busy` out 1: high in any state other than IDLE.
- `bursts_done` out 16: count of `fr_eof` rising edges; wraps.

## Operation
- States:
  - ST_IDLE: `cmd_tready`=1. `trig_tvalid`=`free_run`, `trig_tlast`=0.
  - ST_DELAY: `trig_tvalid`=1, `trig_tlast` = (cnt==0).
  - ST_CONFIG: one cycle. `trig_tvalid`=0.
- IDLE, on `cmd_tvalid & cmd_tready`:
  - latch num_symbols; load cnt = delay.
  - → DELAY.
  - A simultaneous free-run idle beat handshake in that cycle is not counted.
- DELAY, on each trigger handshake:
  - if cnt != 0: cnt-1 (non-last beat).
  - if cnt == 0: beat has `tlast`=1 and `tdata`=seq. Then seq+1, → CONFIG.
  - Delay D therefore yields D non-last beats followed by the trigger beat. D=0 makes the first beat the trigger beat.
- CONFIG, short write condition: num_symbols != 0 and num_symbols < `numsymbols_max`.
  - If the condition holds: `fr_set_stb`=1, `fr_set_addr`=`SR_NUMBER_SYMBOLS_SHORT`, `fr_set_data`={16'd0, num_symbols}.
  - Otherwise no write; the framer runs a full-length burst.
  - Always → IDLE.
- The write lands while the framer is in its offset phase, after it has left wait-for-trigger. This timing is mandatory: a write issued while the framer is waiting is cancelled by it.
- Deasserting `trig_tready` mid-DELAY holds the current beat stable (AXI rules). cnt does not change.
- `bursts_done` increments on `fr_eof` & ~`fr_eof_d`, independent of state.
- Command spacing is software's responsibility. A trigger issued while the framer is mid-burst is ignored by the framer. The scheduler does not detect this.
- `reset`/`clear`:
  - state, cnt, seq, `bursts_done` → 0; state → IDLE.
  - outputs low; the in-flight command is dropped with no settings write.

## Timing
- Reset values:
  - `cmd_tready`, `trig_tvalid`, `trig_tlast`, `fr_set_stb`, `busy` = 0.
  - `fr_set_addr`, `fr_set_data`, `trig_tdata`, `bursts_done` = 0.
- `cmd_tready` is registered. It is 1 the cycle after reset release, and deasserts the cycle after a command is accepted.
- Command accepted in cycle N → first DELAY beat offered in N+1.
- Trigger-beat handshake in cycle T → `fr_set_stb` high exactly in T+1, single cycle → IDLE in T+2, `cmd_tready`=1 in T+2.
- `trig_tlast`/`trig_tvalid` are combinational from state and cnt. There is no combinational path from `trig_tready` to `trig_tvalid`.
- Back-to-back commands: minimum gap of 2 idle cycles between one trigger beat and the next command's first beat.

## Structure
- Shared package `periodic_framer_sched_pkg`:
  - state localparams (2-bit encoding);
  - command field offsets: NSYM_LSB=32, DELAY_LSB=0.
- No sub-module: a single FSM plus delay counter, sequence counter and eof edge detector in one file.
- The command FIFO (`axi_fifo`) is instantiated by the parent, not inside the block.

## Test plan
- Delay=3, nsym=2, max=8, `trig_tready`=1: 3 beats with `tlast`=0, then one beat with `tlast`=1, `tdata`=0. `fr_set_stb` in the next cycle with addr 4, data 0x0000_0002.
- Delay=0, nsym=8, max=8: the first beat is the trigger. No `fr_set_stb` (full burst). Also with nsym=0: no write.
- Random `trig_tready` stalls during delay=5: exactly 5 non-last beats handshaked before `tlast`. `tdata`/`tlast` stable while stalled.
- Two queued commands: second trigger `tdata`=1. `cmd_tready` rises exactly 2 cycles after the first trigger handshake.
- `free_run`=0 idle: `trig_tvalid` stays 0. `free_run`=1 idle: continuous `tlast`=0 beats.
- `clear` asserted mid-DELAY (cnt=2): no `tlast` and no `fr_set_stb`; IDLE next cycle. Three `fr_eof` pulses → `bursts_done`=3; a held-high `fr_eof` counts once.
